fifo_uart_tx: RTL
=================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port fifo_empty, input, 1 bit: the upstream FIFO empty flag.
REQ-005 The block SHALL have port fifo_data, input, 8 bits: the upstream FIFO data output, valid the cycle after a read is sampled.
REQ-006 The block SHALL have port fifo_rd, output, 1 bit: read strobe to the upstream FIFO, one cycle per byte.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on the last cycle of each stop bit.

Function
REQ-010 The FSM SHALL have states IDLE, REQ, LOAD, START, DATA, PARITY, STOP; all outputs SHALL be registered or decoded from registered state only.
REQ-011 In IDLE with fifo_empty=0 the FSM SHALL move to REQ; with fifo_empty=1 it SHALL stay in IDLE with fifo_rd=0.
REQ-012 fifo_rd SHALL be 1 exactly during the single REQ cycle and 0 in every other state.
REQ-013 REQ SHALL always advance to LOAD; at the end of LOAD fifo_data SHALL be captured into an 8-bit shift register and the FSM SHALL move to START.
REQ-014 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then move to DATA.
REQ-015 DATA SHALL drive the 8 captured bits LSB first, each for CLKS_PER_BIT cycles, counted by a 3-bit bit counter that wraps 7->0 on leaving DATA.
REQ-016 After bit 7, DATA SHALL move to PARITY when PARITY_EN is defined, else directly to STOP.
REQ-017 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles and assert frame_done on its last cycle.
REQ-018 At the end of STOP the FSM SHALL go to REQ if fifo_empty=0, else to IDLE, giving exactly 2 idle-high cycles (REQ, LOAD) between back-to-back frames.
REQ-019 tx SHALL be 1 in IDLE, REQ and LOAD.
REQ-020 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL count 0..CLKS_PER_BIT-1, and SHALL clear on every state transition.
REQ-021 fifo_empty SHALL be sampled only in IDLE and on the last STOP cycle; changes in other states SHALL have no effect.

Reset
REQ-022 With rst=1 at a rising edge, next cycle SHALL show state=IDLE, tx=1, fifo_rd=0, busy=0, frame_done=0, and all counters and the shift register at 0.
REQ-023 Reset mid-frame SHALL abort the frame immediately; a byte already popped SHALL be discarded, not retransmitted.
REQ-024 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-025 Macro FIFO_UART_TX_PARITY_EN defined: the PARITY state SHALL drive even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles; frame = 11 bits.
REQ-026 Macro FIFO_UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent; frame = 10 bits.

Verification (CLKS_PER_BIT=4)
REQ-027 Reset: rst=1 for 2 cycles with fifo_empty=0 -> tx=1, fifo_rd=0, busy=0 throughout.
REQ-028 Single byte 0xA5, no parity: one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1 each held 4 cycles (40 cycles); one frame_done pulse; then IDLE.
REQ-029 Back-to-back 0x01 then 0x80: exactly 2 cycles of tx=1 between the end of the first stop bit and the second start bit; 2 fifo_rd pulses total.
REQ-030 Empty: fifo_empty=1 for 100 cycles -> fifo_rd never asserts, tx=1, busy=0.
REQ-031 Reset during DATA bit 3 -> the following cycle tx=1, busy=0; after release with fifo_empty=0, a new fifo_rd pulse starts a fresh frame.
REQ-032 FIFO_UART_TX_PARITY_EN defined: byte 0x07 -> parity bit 1; byte 0xA5 -> parity bit 0; frame length 44 cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// FIFO-fed 8N1 UART transmitter: pops one byte per frame from an upstream FIFO and serialises it.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

  // states: IDLE wait for data | REQ pop strobe | LOAD capture byte | START/DATA/PARITY/STOP serial bits
`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, REQ = 3'd1, LOAD = 3'd2, START = 3'd3, DATA = 3'd4, PARITY = 3'd5, STOP = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, REQ = 3'd1, LOAD = 3'd2, START = 3'd3, DATA = 3'd4, STOP = 3'd6
  } state_t;
`endif

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            parity;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state   <= REQ;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity <= ^fifo_data;
`endif
          tx    <= 1'b0;
          baud  <= '0;
          state <= START;
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= shreg[0];
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx <= shreg[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end
`endif
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            // back-to-back frames skip IDLE so only REQ and LOAD separate them
            if (!fifo_empty) begin
              state   <= REQ;
              fifo_rd <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud       <= baud + BW'(1);
            frame_done <= (baud == BAUD_PRE);
          end
        end
        default: begin
          state <= IDLE;
          baud  <= '0;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
